// File: rtl/dma_pkg.sv
// Shared types and AXI constants for the DMA burst writer.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        RESP = 3'd4,
        DONE = 3'd5
    } dma_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI AxSIZE encoding for a bus of data_w bits.
    function automatic logic [2:0] axi_size(input int unsigned data_w);
        logic [2:0] size;
        case (data_w)
            8:       size = 3'd0;
            16:      size = 3'd1;
            32:      size = 3'd2;
            64:      size = 3'd3;
            128:     size = 3'd4;
            256:     size = 3'd5;
            512:     size = 3'd6;
            1024:    size = 3'd7;
            default: size = 3'd3;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level output and synchronous clear.
module dma_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // A push into a full FIFO is refused even when a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dma_burst_writer.sv
// Captures a free-running sample stream into a memory buffer using fixed-length AXI4 INCR write bursts,
// in one-shot or circular mode.
module dma_burst_writer
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [31:0] BUF_BYTES  = 32'h0010_0000
) (
    input  logic                aclk,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                mode_i,
    input  logic                stop_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                data_valid_i,
    output logic [31:0]         m_axi_awaddr,
    output logic                m_axi_awvalid,
    output logic [3:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    output logic                m_axi_wlast,
    input  logic                m_axi_wready,
    input  logic                m_axi_bvalid,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_bready,
    output logic                finished_o,
    output logic                engaged_o,
    output logic                overflow_o,
    output logic [15:0]         drop_cnt_o,
    output logic                bresp_err_o,
    output logic [31:0]         wr_offset_o,
    output dma_state_e          state_o
);

    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * DATA_W / 8);
    localparam logic [3:0]  LAST_BEAT   = 4'(BURST_LEN - 1);

    dma_state_e        state;
    logic [3:0]        beat_cnt;
    logic              circular;
    logic              stop_pending;

    logic              fifo_clr;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_rdata;
    logic [LVL_W-1:0]  fifo_level;

    logic              sample_drop;
    logic              stop_req;
    logic              buf_end;
    logic [31:0]       next_offset;

    // Handshakes: a transfer happens on a rising aclk edge where valid and ready are both high;
    // a raised valid is held, with its payload stable, until that edge.
    assign sample_drop = engaged_o && data_valid_i && fifo_full;
    assign fifo_push   = engaged_o && data_valid_i && !fifo_full;
    assign fifo_pop    = m_axi_wvalid && m_axi_wready;
    assign fifo_clr    = (state == IDLE && enable_i) || (state == DONE);
    assign stop_req    = stop_i || stop_pending;
    assign next_offset = wr_offset_o + BURST_BYTES;
    assign buf_end     = (next_offset == BUF_BYTES);
    assign state_o     = state;

    assign m_axi_wdata = m_axi_wvalid ? fifo_rdata : '0;
    assign m_axi_wstrb = {(DATA_W/8){m_axi_wvalid}};

    dma_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (rst_ni),
        .clr     (fifo_clr),
        .push    (fifo_push),
        .wr_data (data_i),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    // BASE_ADDR is 4 KiB aligned and BUF_BYTES is a multiple of the burst size, so every burst
    // starts on a burst-size boundary and can never straddle a 4 KiB page.
    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            circular      <= 1'b0;
            stop_pending  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_awlen   <= '0;
            m_axi_awsize  <= '0;
            m_axi_awburst <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
            finished_o    <= 1'b0;
            engaged_o     <= 1'b0;
            overflow_o    <= 1'b0;
            drop_cnt_o    <= '0;
            bresp_err_o   <= 1'b0;
            wr_offset_o   <= '0;
        end else begin
            if (sample_drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) begin
                    drop_cnt_o <= drop_cnt_o + 16'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state        <= FILL;
                        engaged_o    <= 1'b1;
                        circular     <= mode_i;
                        stop_pending <= 1'b0;
                        wr_offset_o  <= '0;
                        drop_cnt_o   <= '0;
                        overflow_o   <= 1'b0;
                        bresp_err_o  <= 1'b0;
                    end
                end

                FILL: begin
                    if (stop_i) begin
                        state      <= DONE;
                        engaged_o  <= 1'b0;
                        finished_o <= 1'b1;
                    end else if (32'(fifo_level) >= BURST_LEN) begin
                        state         <= ADDR;
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= BASE_ADDR + wr_offset_o;
                        m_axi_awlen   <= LAST_BEAT;
                        m_axi_awsize  <= axi_size(DATA_W);
                        m_axi_awburst <= AXI_BURST_INCR;
                    end
                end

                ADDR: begin
                    if (stop_i) begin
                        stop_pending <= 1'b1;
                    end
                    if (m_axi_awready) begin
                        state         <= DATA;
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wlast   <= (BURST_LEN == 1);
                        beat_cnt      <= '0;
                    end
                end

                DATA: begin
                    if (stop_i) begin
                        stop_pending <= 1'b1;
                    end
                    if (m_axi_wready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state        <= RESP;
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                        end else begin
                            beat_cnt    <= beat_cnt + 4'd1;
                            m_axi_wlast <= ((beat_cnt + 4'd1) == LAST_BEAT);
                        end
                    end
                end

                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != AXI_RESP_OKAY) begin
                            bresp_err_o <= 1'b1;
                        end
                        wr_offset_o <= (circular && buf_end) ? '0 : next_offset;
                        if (stop_req || (!circular && buf_end)) begin
                            state        <= DONE;
                            engaged_o    <= 1'b0;
                            finished_o   <= 1'b1;
                            stop_pending <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end else if (stop_i) begin
                        stop_pending <= 1'b1;
                    end
                end

                DONE: begin
                    if (!enable_i) begin
                        state      <= IDLE;
                        finished_o <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_writer.sv
// Directed bench for dma_burst_writer: a small AXI write slave, a sample source and scenario checks.
module tb_dma_burst_writer;
    import dma_pkg::*;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned BURST_LEN  = 16;
    localparam int unsigned FIFO_DEPTH = 32;
    localparam logic [31:0] BASE_ADDR  = 32'h1000_0000;
    localparam logic [31:0] BUF_BYTES  = 32'h0000_0100;

    // clock / reset and DUT signals
    logic              aclk;
    logic              rst_ni;
    logic              enable_i;
    logic              mode_i;
    logic              stop_i;
    logic [DATA_W-1:0] data_i;
    logic              data_valid_i;
    logic [31:0]       m_axi_awaddr;
    logic              m_axi_awvalid;
    logic [3:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [7:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wlast;
    logic              m_axi_wready;
    logic              m_axi_bvalid;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bready;
    logic              finished_o;
    logic              engaged_o;
    logic              overflow_o;
    logic [15:0]       drop_cnt_o;
    logic              bresp_err_o;
    logic [31:0]       wr_offset_o;
    dma_state_e        state_o;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    dma_burst_writer #(
        .DATA_W     (DATA_W),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .BUF_BYTES  (BUF_BYTES)
    ) dut (
        .aclk          (aclk),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .mode_i        (mode_i),
        .stop_i        (stop_i),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready),
        .finished_o    (finished_o),
        .engaged_o     (engaged_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o),
        .bresp_err_o   (bresp_err_o),
        .wr_offset_o   (wr_offset_o),
        .state_o       (state_o)
    );

    // scoreboard
    int                total;
    int                bad;
    logic [DATA_W-1:0] exp_q[$];
    logic [31:0]       aw_q[$];
    logic [DATA_W-1:0] w_q[$];
    logic              wl_q[$];
    logic [31:0]       off_q[$];

    // slave / source knobs and state
    int                aw_hold;
    int                aw_wait;
    int                aw_stall;
    logic              aw_seen;
    logic [31:0]       aw_first;
    logic [3:0]        rec_len;
    logic [2:0]        rec_size;
    logic [1:0]        rec_burst;
    logic [7:0]        rec_strb;
    logic              w_toggle;
    logic              w_phase;
    int                w_low_left;
    int                wlast_cnt;
    logic              wvalid_early;
    logic [1:0]        bresp_first;
    logic [1:0]        bresp_rest;
    logic              b_pending;
    logic              b_fire;
    int                b_count;
    int                src_left;
    logic              src_cont;
    logic [DATA_W-1:0] src_val;
    logic              extra_on_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        aw_q.delete();
        w_q.delete();
        wl_q.delete();
        off_q.delete();
        aw_hold = 0; aw_wait = 0; aw_stall = 0; aw_seen = 1'b0; aw_first = '0;
        rec_len = '0; rec_size = '0; rec_burst = '0; rec_strb = '0;
        w_toggle = 1'b0; w_phase = 1'b0; w_low_left = 0; wlast_cnt = 0; wvalid_early = 1'b0;
        bresp_first = 2'b00; bresp_rest = 2'b00;
        b_pending = 1'b0; b_fire = 1'b0; b_count = 0;
        src_left = 0; src_cont = 1'b0; src_val = '0; extra_on_pop = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        data_valid_i = 1'b0; data_i = '0;
    endtask

    // One cycle of driver work at the falling edge; ready/valid chosen here take effect at the next rising edge.
    task automatic step();
        @(negedge aclk);
        if (b_fire) begin
            m_axi_bvalid = 1'b0;
            b_fire = 1'b0;
            off_q.push_back(wr_offset_o);
        end
        if (b_pending && !m_axi_bvalid) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (b_count == 0) ? bresp_first : bresp_rest;
            b_pending    = 1'b0;
        end
        m_axi_awready = 1'b0;
        if (m_axi_awvalid) begin
            if (!aw_seen) begin
                aw_first = m_axi_awaddr;
                aw_seen  = 1'b1;
            end
            if (aw_wait < aw_hold) begin
                aw_wait++;
                aw_stall++;
            end else begin
                m_axi_awready = 1'b1;
            end
        end
        if (m_axi_wvalid && w_low_left > 0) begin
            w_low_left--;
            m_axi_wready = 1'b0;
        end else if (w_toggle) begin
            w_phase = !w_phase;
            m_axi_wready = w_phase;
        end else begin
            m_axi_wready = 1'b1;
        end
        if (src_left > 0) begin
            data_valid_i = 1'b1; data_i = src_val; src_val++; src_left--;
        end else if (src_cont) begin
            data_valid_i = 1'b1; data_i = src_val; src_val++;
        end else begin
            data_valid_i = 1'b0;
        end
        if (extra_on_pop && m_axi_wvalid && m_axi_wready) begin
            data_valid_i = 1'b1; data_i = 64'hDEAD; extra_on_pop = 1'b0;
        end
        if (m_axi_awvalid && m_axi_awready) begin
            aw_q.push_back(m_axi_awaddr);
            rec_len = m_axi_awlen; rec_size = m_axi_awsize; rec_burst = m_axi_awburst;
            aw_wait = 0;
            aw_seen = 1'b0;
        end
        if (m_axi_wvalid && aw_q.size() == wlast_cnt) begin
            wvalid_early = 1'b1;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            w_q.push_back(m_axi_wdata);
            wl_q.push_back(m_axi_wlast);
            rec_strb = m_axi_wstrb;
            if (m_axi_wlast) begin
                wlast_cnt++;
                b_pending = 1'b1;
            end
        end
        if (m_axi_bvalid && m_axi_bready) begin
            b_fire = 1'b1;
            b_count++;
        end
    endtask

    task automatic expect_beats(input logic [DATA_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(first + DATA_W'(i));
        end
    endtask

    task automatic check_beats(input string tag);
        int idx;
        idx = 0;
        check({tag, "_beat_count"}, 64'(w_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            check({tag, "_beat"}, (idx < w_q.size()) ? w_q[idx] : 64'hBAD0_BAD0, e);
            idx++;
        end
    endtask

    function automatic logic [31:0] last_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < wl_q.size() && i < 32; i++) begin
            m[i] = wl_q[i];
        end
        return m;
    endfunction

    function automatic logic [31:0] aw_at(input int i);
        return (i < aw_q.size()) ? aw_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] off_at(input int i);
        return (i < off_q.size()) ? off_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic start_capture(input logic circ);
        mode_i = circ;
        enable_i = 1'b1;
        step(); step(); step();
    endtask

    task automatic end_capture();
        src_cont = 1'b0;
        src_left = 0;
        enable_i = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        rst_ni = 1'b0;
        enable_i = 1'b0;
        mode_i = 1'b0;
        stop_i = 1'b0;
        clear_mon();
        repeat (3) step();

        // reset state
        check("rst_awvalid", 64'(m_axi_awvalid), 0);
        check("rst_wvalid", 64'(m_axi_wvalid), 0);
        check("rst_wlast", 64'(m_axi_wlast), 0);
        check("rst_bready", 64'(m_axi_bready), 0);
        check("rst_finished", 64'(finished_o), 0);
        check("rst_engaged", 64'(engaged_o), 0);
        check("rst_overflow", 64'(overflow_o), 0);
        check("rst_drop_cnt", 64'(drop_cnt_o), 0);
        check("rst_bresp_err", 64'(bresp_err_o), 0);
        check("rst_offset", 64'(wr_offset_o), 0);
        rst_ni = 1'b1;
        repeat (2) step();

        // one-shot, two bursts over a 256-byte buffer
        clear_mon();
        start_capture(1'b0);
        src_val = 64'h100;
        src_cont = 1'b1;
        for (int i = 0; i < 400 && !finished_o; i++) step();
        check("os_finished", 64'(finished_o), 1);
        src_cont = 1'b0;
        repeat (10) step();
        check("os_aw_count", 64'(aw_q.size()), 2);
        check("os_aw0", 64'(aw_at(0)), 64'h1000_0000);
        check("os_aw1", 64'(aw_at(1)), 64'h1000_0080);
        check("os_awlen", 64'(rec_len), 15);
        check("os_awsize", 64'(rec_size), 3);
        check("os_awburst", 64'(rec_burst), 1);
        check("os_wstrb", 64'(rec_strb), 64'hFF);
        expect_beats(64'h100, 32);
        check_beats("os");
        check("os_wlast_mask", 64'(last_mask()), 64'h8000_8000);
        check("os_offset", 64'(wr_offset_o), 64'h100);
        check("os_engaged", 64'(engaged_o), 0);
        check("os_overflow", 64'(overflow_o), 0);
        check("os_drop_cnt", 64'(drop_cnt_o), 0);
        check("os_bresp_err", 64'(bresp_err_o), 0);
        end_capture();
        check("os_finished_clear", 64'(finished_o), 0);

        // circular: third burst wraps to the buffer start
        clear_mon();
        start_capture(1'b1);
        src_cont = 1'b1;
        for (int i = 0; i < 600 && b_count < 3; i++) step();
        check("circ_three_resp", 64'(b_count >= 3), 1);
        step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        for (int i = 0; i < 200 && !finished_o; i++) step();
        check("circ_finished", 64'(finished_o), 1);
        check("circ_aw0", 64'(aw_at(0)), 64'h1000_0000);
        check("circ_aw1", 64'(aw_at(1)), 64'h1000_0080);
        check("circ_aw2", 64'(aw_at(2)), 64'h1000_0000);
        check("circ_off0", 64'(off_at(0)), 64'h80);
        check("circ_off1", 64'(off_at(1)), 64'h00);
        check("circ_off2", 64'(off_at(2)), 64'h80);
        end_capture();

        // AW stalled 20 cycles, W ready toggling, then stop while waiting in FILL
        clear_mon();
        aw_hold = 20;
        w_toggle = 1'b1;
        start_capture(1'b0);
        src_val = 64'hA000;
        src_left = 16;
        for (int i = 0; i < 300 && b_count < 1; i++) step();
        check("stall_resp_seen", 64'(b_count), 1);
        check("stall_aw_low_cycles", 64'(aw_stall), 20);
        check("stall_awaddr_first", 64'(aw_first), 64'h1000_0000);
        check("stall_awaddr_hs", 64'(aw_at(0)), 64'h1000_0000);
        check("stall_wvalid_early", 64'(wvalid_early), 0);
        expect_beats(64'hA000, 16);
        check_beats("stall");
        check("stall_wlast_mask", 64'(last_mask()), 64'h8000);
        repeat (5) step();
        check("stall_fill_engaged", 64'(engaged_o), 1);
        check("stall_fill_offset", 64'(wr_offset_o), 64'h80);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("fill_stop_finished", 64'(finished_o), 1);
        check("fill_stop_engaged", 64'(engaged_o), 0);
        repeat (10) step();
        check("fill_stop_aw_count", 64'(aw_q.size()), 1);
        end_capture();

        // overflow: W held off 40 cycles, 50 samples plus one landing on the first pop
        clear_mon();
        w_low_left = 40;
        extra_on_pop = 1'b1;
        start_capture(1'b0);
        src_val = 64'h0;
        src_left = 50;
        for (int i = 0; i < 500 && !finished_o; i++) step();
        check("ovf_finished", 64'(finished_o), 1);
        check("ovf_flag", 64'(overflow_o), 1);
        check("ovf_drop_cnt", 64'(drop_cnt_o), 19);
        check("ovf_aw_count", 64'(aw_q.size()), 2);
        expect_beats(64'h0, 32);
        check_beats("ovf");
        end_capture();

        // stop during beat 5: burst completes, no further AW
        clear_mon();
        start_capture(1'b0);
        src_val = 64'h500;
        src_cont = 1'b1;
        for (int i = 0; i < 200 && w_q.size() < 5; i++) step();
        check("stop5_reached", 64'(w_q.size()), 5);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        for (int i = 0; i < 200 && !finished_o; i++) step();
        check("stop5_finished", 64'(finished_o), 1);
        src_cont = 1'b0;
        repeat (20) step();
        check("stop5_aw_count", 64'(aw_q.size()), 1);
        expect_beats(64'h500, 16);
        check_beats("stop5");
        check("stop5_wlast_mask", 64'(last_mask()), 64'h8000);
        check("stop5_offset", 64'(wr_offset_o), 64'h80);
        end_capture();

        // SLVERR on the first burst, then reset in the middle of the second burst's data phase
        clear_mon();
        bresp_first = 2'b10;
        start_capture(1'b0);
        src_cont = 1'b1;
        for (int i = 0; i < 300 && aw_q.size() < 2; i++) step();
        check("berr_flag", 64'(bresp_err_o), 1);
        check("berr_aw1", 64'(aw_at(1)), 64'h1000_0080);
        for (int i = 0; i < 100 && w_q.size() < 19; i++) step();
        check("berr_mid_data", 64'(m_axi_wvalid), 1);
        rst_ni = 1'b0;
        #1;
        check("arst_awvalid", 64'(m_axi_awvalid), 0);
        check("arst_wvalid", 64'(m_axi_wvalid), 0);
        check("arst_wlast", 64'(m_axi_wlast), 0);
        check("arst_wdata", 64'(m_axi_wdata), 0);
        check("arst_bready", 64'(m_axi_bready), 0);
        check("arst_engaged", 64'(engaged_o), 0);
        check("arst_finished", 64'(finished_o), 0);
        check("arst_overflow", 64'(overflow_o), 0);
        check("arst_drop_cnt", 64'(drop_cnt_o), 0);
        check("arst_bresp_err", 64'(bresp_err_o), 0);
        check("arst_offset", 64'(wr_offset_o), 0);
        enable_i = 1'b0;
        clear_mon();
        repeat (2) step();
        rst_ni = 1'b1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_burst_writer.md
DMA_BURST_WRITER -- requirements
Module: dma_burst_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, stream and AXI write-data width in bits (64 or 32).
REQ-002 SHALL have parameter BURST_LEN, default 16, beats per burst (1..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, staging FIFO entries (power of 2, >= 2*BURST_LEN).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h1000_0000, buffer start (4 KiB aligned).
REQ-005 SHALL have parameter BUF_BYTES, default 32'h0010_0000, buffer size (power of 2, multiple of burst bytes).
REQ-006 SHALL have port aclk  in  1  single clock for all logic.
REQ-007 SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port enable_i  in  1  level; high starts and holds a capture.
REQ-009 SHALL have port mode_i  in  1  0 one-shot, 1 circular; sampled on IDLE exit.
REQ-010 SHALL have port stop_i  in  1  requests graceful stop.
REQ-011 SHALL have port data_i / data_valid_i  in  DATA_W / 1  sample stream, no backpressure.
REQ-012 SHALL have ports m_axi_awaddr[32], awvalid, awlen[4], awsize[3], awburst[2] out, and awready in.
REQ-013 SHALL have ports m_axi_wdata[DATA_W], wstrb[DATA_W/8], wvalid, wlast out, and wready in.
REQ-014 SHALL have ports m_axi_bvalid in, bresp[2] in, and bready out.
REQ-015 SHALL have port finished_o  out  1  capture complete.
REQ-016 SHALL have port engaged_o  out  1  capture in progress.
REQ-017 SHALL have port overflow_o  out  1  sticky sample-drop flag.
REQ-018 SHALL have port drop_cnt_o  out  16  saturating dropped-sample count.
REQ-019 SHALL have port bresp_err_o  out  1  sticky non-OKAY response.
REQ-020 SHALL have port wr_offset_o  out  32  byte offset of the next burst.

Function
REQ-021 SHALL implement states IDLE, FILL, ADDR, DATA, RESP, DONE.
REQ-022 SHALL leave IDLE for FILL when enable_i=1, and on that transition clear FIFO, offset, drop_cnt, overflow and bresp_err.
REQ-023 SHALL go FILL->ADDR when FIFO level >= BURST_LEN.
REQ-024 SHALL hold awvalid high in ADDR until awready, with awaddr=BASE_ADDR+offset, awlen=BURST_LEN-1, awsize=log2(DATA_W/8), awburst=INCR(01).
REQ-025 SHALL, in DATA, pop one FIFO entry per wvalid&&wready cycle, with wstrb all ones and wlast only on beat BURST_LEN-1; wvalid only asserts after the AW handshake.
REQ-026 SHALL hold bready=1 in RESP, and on bvalid set bresp_err if bresp!=00 and advance offset by BURST_LEN*DATA_W/8.
REQ-027 SHALL, in one-shot mode, go to DONE when offset reaches BUF_BYTES, setting finished_o=1.
REQ-028 SHALL, in circular mode, wrap offset to 0 and continue in FILL.
REQ-029 SHALL, when stop_i is seen in FILL, go to DONE at once; when seen in ADDR/DATA/RESP, complete the burst then go to DONE; residual FIFO data is discarded.
REQ-030 SHALL remain in DONE until enable_i=0, then return to IDLE and clear finished_o.
REQ-031 SHALL set engaged_o=1 in FILL/ADDR/DATA/RESP.
REQ-032 SHALL push samples only while engaged.
REQ-033 SHALL drop a sample when data_valid_i=1 and the FIFO is full (evaluated pre-pop, even if a pop occurs that cycle), setting overflow_o and incrementing drop_cnt_o, saturating at 16'hFFFF.
REQ-034 SHALL guarantee no burst crosses a 4 KiB boundary, which follows from the alignment parameters.

Reset
REQ-035 SHALL, while rst_ni=0, asynchronously force state IDLE, empty FIFO, and all outputs 0 (awvalid, wvalid, wlast, bready, flags, counters, offset); an in-flight burst is abandoned.

Structure
REQ-036 SHALL take the state enum, AXI_BURST_INCR, AXI_RESP_OKAY and the awsize helper function from shared package dma_pkg.
REQ-037 SHALL instantiate one sub-module dma_sync_fifo (DATA_W x FIFO_DEPTH, level output, first-word-fall-through).

Verification
REQ-038 SHALL cover: one-shot, BUF_BYTES=256, BURST_LEN=16, DATA_W=64, continuous valid -> exactly 2 bursts at 0x1000_0000 and 0x1000_0080, then finished_o=1.
REQ-039 SHALL cover: circular, BUF_BYTES=256 -> third burst at 0x1000_0000, and wr_offset_o sequence 0x80, 0x00, 0x80.
REQ-040 SHALL cover: awready held low 20 cycles, then wready toggling -> awaddr stable, 16 beats in order, wlast on 16th only.
REQ-041 SHALL cover: FIFO_DEPTH=32, wready low 40 cycles with continuous valid -> overflow_o=1 and drop_cnt_o equal to the number of samples pushed into the full FIFO.
REQ-042 SHALL cover: stop_i at beat 5 of a burst -> burst finishes with all 16 beats, then DONE, and no further AW.
REQ-043 SHALL cover: bresp=10 on the first burst -> bresp_err_o=1 and capture continues; rst_ni low mid-DATA -> all outputs 0 within the same cycle.
